// File: rtl/seq_divider_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the iterative divider.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITER  = DIV_WIDTH;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Adder/subtractor: returns {cout, sum}; in subtract mode cout=1 means no borrow.
  function automatic logic [DIV_WIDTH:0] add_sub(input logic [DIV_WIDTH-1:0] a,
                                                 input logic [DIV_WIDTH-1:0] b,
                                                 input logic                 sub);
    logic [DIV_WIDTH-1:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + (DIV_WIDTH+1)'(sub);
  endfunction

  // Two's complement negation as 0 - x through the subtract path.
  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
    logic [DIV_WIDTH:0] s;
    s = add_sub('0, x, 1'b1);
    return s[DIV_WIDTH-1:0];
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division step: shift {R,Q} left and try to subtract the divisor.
module seq_divider_step
  import seq_divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] r,
  input  logic [DIV_WIDTH-1:0] q,
  input  logic [DIV_WIDTH-1:0] b_abs,
  output logic [DIV_WIDTH-1:0] r_next_c,
  output logic [DIV_WIDTH-1:0] q_next_c
);

  logic [DIV_WIDTH-1:0] shifted;
  logic [DIV_WIDTH:0]   diff;
  logic                 no_borrow;

  // Partial remainder stays below |B| <= 2^31, so the shifted value fits in 32 bits.
  always_comb begin
    shifted   = {r[DIV_WIDTH-2:0], q[DIV_WIDTH-1]};
    diff      = add_sub(shifted, b_abs, 1'b1);
    no_borrow = diff[DIV_WIDTH];
    r_next_c  = no_borrow ? diff[DIV_WIDTH-1:0] : shifted;
    q_next_c  = {q[DIV_WIDTH-2:0], no_borrow};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring step per clock, sign fix-up at the end.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ctrl_div,
  input  logic [DIV_WIDTH-1:0] data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  output logic [DIV_WIDTH-1:0] data_result,
  output logic [DIV_WIDTH-1:0] data_remainder,
  output logic                 data_exception,
  output logic                 data_resultRDY
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DIV_WIDTH-1:0] r_q, r_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [DIV_WIDTH-1:0] b_q, b_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [DIV_WIDTH-1:0] result_q, result_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  logic [DIV_WIDTH-1:0] r_step_c;
  logic [DIV_WIDTH-1:0] q_step_c;

  seq_divider_step u_step (
    .r        (r_q),
    .q        (q_q),
    .b_abs    (b_q),
    .r_next_c (r_step_c),
    .q_next_c (q_step_c)
  );

  // State and datapath registers; reset aborts any division in progress.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      count_q  <= '0;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      r_q      <= r_d;
      q_q      <= q_d;
      b_q      <= b_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state and datapath: a start in any state relatches and restarts.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    r_d      = r_q;
    q_d      = q_q;
    b_d      = b_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rem_d    = rem_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (ctrl_div) begin
      r_d     = '0;
      q_d     = abs_val(data_operandA);
      b_d     = abs_val(data_operandB);
      qneg_d  = data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
      rneg_d  = data_operandA[DIV_WIDTH-1];
      count_d = '0;
      state_d = (data_operandB == '0) ? DIV_FIX : DIV_RUN;
    end else begin
      case (state_q)
        DIV_RUN: begin
          r_d     = r_step_c;
          q_d     = q_step_c;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          // A zero divisor skips RUN, so Q still holds |A| and restores A unchanged.
          if (b_q == '0) begin
            result_d = '0;
            rem_d    = rneg_q ? negate(q_q) : q_q;
            exc_d    = 1'b1;
          end else begin
            result_d = qneg_q ? negate(q_q) : q_q;
            rem_d    = rneg_q ? negate(r_q) : r_q;
            exc_d    = 1'b0;
          end
          rdy_d   = 1'b1;
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expectations, monitor checks on ready.
module tb_seq_divider;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int unsigned due;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  seq_divider dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready @cyc %0d: got ready=1 expected ready=0", cyc);
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.due));
        chk("result", data_result, e.res);
        chk("remainder", data_remainder, e.rem);
        chk("exception", 32'(data_exception), 32'(e.exc));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_ready @cyc %0d: got no ready expected one at cyc %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // Pulse ctrl_div for one edge; entered and left just after a falling edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    @(negedge clock);
    ctrl_div      = 1'b0;
  endtask

  // Issue one division and return in its ready cycle so the next start overlaps ready.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [31:0] rem, input logic exc);
    exp_t        e;
    int unsigned lat;
    lat   = (b == 32'd0) ? 1 : 33;
    e.res = res;
    e.rem = rem;
    e.exc = exc;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    start(a, b);
    repeat (lat) @(negedge clock);
  endtask

  logic [31:0] va [17] = '{32'd100, 32'hFFFFFF9C, 32'd5, 32'h80000000, 32'd100, 32'hFFFFFF9C,
                           32'd7, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                           32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9, 32'd1000000, 32'd9};
  logic [31:0] vb [17] = '{32'd7, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                           32'd100, 32'd5, 32'd0, 32'd1, 32'd1, 32'd2,
                           32'h80000000, 32'h80000000, 32'd2, 32'd3, 32'hFFFFFFFD};
  logic [31:0] vr [17] = '{32'd14, 32'hFFFFFFF2, 32'd0, 32'h80000000, 32'hFFFFFFF2, 32'd14,
                           32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hC0000000,
                           32'd1, 32'd0, 32'hFFFFFFFD, 32'd333333, 32'hFFFFFFFD};
  logic [31:0] vm [17] = '{32'd2, 32'hFFFFFFFE, 32'd5, 32'd0, 32'd2, 32'hFFFFFFFE,
                           32'd7, 32'd0, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0,
                           32'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0};
  logic        ve [17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [31:0] ra, rb, er, em;
    resetn        = 1'b0;
    ctrl_div      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_remainder", data_remainder, 32'd0);
    chk("reset_exception", 32'(data_exception), 32'd0);
    chk("reset_ready", 32'(data_resultRDY), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 17; i++) begin
      run(va[i], vb[i], vr[i], vm[i], ve[i]);
    end

    // Abort 100/7 after ten cycles with 9/-3; only the restart may report.
    repeat (2) @(negedge clock);
    start(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    run(32'd9, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 1'b0);

    // Reset mid-division clears outputs and suppresses the pending result.
    repeat (2) @(negedge clock);
    start(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_remainder", data_remainder, 32'd0);
    chk("midreset_exception", 32'(data_exception), 32'd0);
    chk("midreset_ready", 32'(data_resultRDY), 32'd0);
    resetn = 1'b1;
    repeat (40) @(negedge clock);
    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Random signed pairs against the language's own / and %.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 20));
      if (i % 4 == 1) rb = -rb;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      er = $signed(ra) / $signed(rb);
      em = $signed(ra) % $signed(rb);
      run(ra, rb, er, em, 1'b0);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
